decode_job_arbiter: RTL and testbench

Schedules one Helios decoder between two syndrome-frame requesters. Arbitrates round-robin between them and serialises the winning packed measurement frame into the decoder's 8-bit input stream (header plus payload). Collects the fixed-length response message and returns it, tagged with the requester id. Sits between the acquisition front-ends and the `Helios_single_FPGA` input/output byte ports.

---
 rtl/decode_job_arbiter_pkg.sv | 26 ++
 rtl/decode_job_arbiter_rr.sv | 21 ++
 rtl/decode_job_arbiter.sv | 177 +++++++++++++++++
 tb/tb_decode_job_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_job_arbiter_pkg.sv
// rtl/decode_job_arbiter_pkg.sv - shared constants, state enum and frame sizing helpers
package decode_job_arbiter_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    typedef enum logic [2:0] {
        SYNC      = 3'd0,
        IDLE      = 3'd1,
        HEADER    = 3'd2,
        PAYLOAD   = 3'd3,
        WAIT_RESP = 3'd4,
        COLLECT   = 3'd5,
        DELIVER   = 3'd6
    } job_state_t;

    // One round of X*Z syndrome bits, padded up to whole bytes
    function automatic int bytes_per_round(input int gx, input int gz);
        return (gx * gz + 7) >> 3;
    endfunction

    function automatic int frame_bytes(input int gx, input int gz, input int gu);
        return bytes_per_round(gx, gz) * gu;
    endfunction

endpackage

// File: rtl/decode_job_arbiter_rr.sv
// rtl/decode_job_arbiter_rr.sv - two-way round-robin grant favouring the requester not served last
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_id,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       grant_any
);

    // On a tie the requester that was not served last wins; otherwise the lone requester wins
    always_comb begin
        grant_any = |req;
        if (req == 2'b11) begin
            grant_id = ~last_id;
        end else begin
            grant_id = req[1];
        end
        grant = grant_any ? (2'b01 << grant_id) : 2'b00;
    end

endmodule

// File: rtl/decode_job_arbiter.sv
// rtl/decode_job_arbiter.sv - shares one Helios decoder between two frame requesters
module decode_job_arbiter
    import decode_job_arbiter_pkg::*;
#(
    parameter int GRID_WIDTH_X   = 6,
    parameter int GRID_WIDTH_Z   = 3,
    parameter int GRID_WIDTH_U   = 5,
    parameter int RESP_BYTES     = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int BYTES_PER_ROUND = bytes_per_round(GRID_WIDTH_X, GRID_WIDTH_Z),
    localparam int FRAME_BYTES     = BYTES_PER_ROUND * GRID_WIDTH_U,
    localparam int FRAME_BITS      = 8 * FRAME_BYTES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*FRAME_BITS-1:0] req_frame,
    output logic [7:0]              dec_in_data,
    output logic                    dec_in_valid,
    input  logic                    dec_in_ready,
    input  logic [7:0]              dec_out_data,
    input  logic                    dec_out_valid,
    output logic                    dec_out_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_id,
    output logic [7:0]              resp_iterations,
    output logic [15:0]             resp_cycles,
    output logic                    resp_timeout,
    output logic                    busy
);

    localparam int CNT_MAX = (FRAME_BYTES > RESP_BYTES) ? FRAME_BYTES : RESP_BYTES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

    job_state_t            state_q;
    job_state_t            state_d;
    logic [FRAME_BITS-1:0] frame_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WD_W-1:0]       wdog_q;
    logic                  last_id_q;

    logic [1:0] arb_req;
    logic [1:0] grant;
    logic       grant_id;
    logic       grant_any;
    logic       in_hs;
    logic       out_hs;
    logic       last_byte;
    logic       last_resp;
    logic       wd_expire;

    // Requests are only looked at while IDLE; changes during a job are ignored
    assign arb_req   = (state_q == IDLE) ? req_valid : 2'b00;
    assign in_hs     = dec_in_valid & dec_in_ready;
    assign out_hs    = dec_out_valid & dec_out_ready;
    assign last_byte = (cnt_q == CNT_W'(FRAME_BYTES - 1));
    assign last_resp = (cnt_q == CNT_W'(RESP_BYTES - 1));
    assign wd_expire = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    rr_arbiter2 u_rr (
        .req       (arb_req),
        .last_id   (last_id_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (in_hs) state_d = IDLE;
            IDLE:    if (grant_any) state_d = HEADER;
            HEADER:  if (in_hs) state_d = PAYLOAD;
            PAYLOAD: if (in_hs && last_byte) state_d = WAIT_RESP;
            WAIT_RESP, COLLECT: begin
                if (out_hs) begin
                    state_d = last_resp ? DELIVER : COLLECT;
                end else if (wd_expire) begin
                    state_d = DELIVER;
                end
            end
            DELIVER: if (resp_ready) state_d = resp_timeout ? SYNC : IDLE;
            default: state_d = SYNC;
        endcase
    end

    // Outputs decoded from registered state; req_ready is the grant of this IDLE cycle
    always_comb begin
        dec_in_valid  = 1'b0;
        dec_in_data   = 8'h00;
        dec_out_ready = 1'b0;
        resp_valid    = 1'b0;
        req_ready     = 2'b00;
        busy          = (state_q != IDLE);
        case (state_q)
            SYNC: begin
                dec_in_valid = 1'b1;
                dec_in_data  = START_DECODING_MSG;
            end
            IDLE:    req_ready = grant;
            HEADER: begin
                dec_in_valid = 1'b1;
                dec_in_data  = MEASUREMENT_DATA_HEADER;
            end
            PAYLOAD: begin
                dec_in_valid = 1'b1;
                dec_in_data  = frame_q[7:0];
            end
            WAIT_RESP, COLLECT: dec_out_ready = 1'b1;
            DELIVER: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: frame shift register, byte/watchdog counters and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q         <= '0;
            cnt_q           <= '0;
            wdog_q          <= '0;
            last_id_q       <= 1'b1;
            resp_id         <= 1'b0;
            resp_iterations <= 8'h00;
            resp_cycles     <= 16'h0000;
            resp_timeout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        frame_q         <= req_frame[grant_id*FRAME_BITS +: FRAME_BITS];
                        last_id_q       <= grant_id;
                        resp_id         <= grant_id;
                        resp_iterations <= 8'h00;
                        resp_cycles     <= 16'h0000;
                        resp_timeout    <= 1'b0;
                        cnt_q           <= '0;
                        wdog_q          <= '0;
                    end
                end
                PAYLOAD: begin
                    if (in_hs) begin
                        frame_q <= frame_q >> 8;
                        cnt_q   <= last_byte ? '0 : cnt_q + 1'b1;
                        wdog_q  <= '0;
                    end
                end
                WAIT_RESP, COLLECT: begin
                    if (out_hs) begin
                        wdog_q <= '0;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(0)) resp_iterations   <= dec_out_data;
                        if (cnt_q == CNT_W'(1)) resp_cycles[15:8] <= dec_out_data;
                        if (cnt_q == CNT_W'(2)) resp_cycles[7:0]  <= dec_out_data;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (wd_expire) resp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_job_arbiter.sv
// tb/tb_decode_job_arbiter.sv - directed self-checking bench for decode_job_arbiter
module tb_decode_job_arbiter;

    localparam int FB    = 15;
    localparam int FBITS = 8 * FB;
    localparam logic [7:0] START = 8'h01;
    localparam logic [7:0] HDR   = 8'h02;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [2*FBITS-1:0] req_frame = '0;
    logic [7:0]       dec_in_data;
    logic             dec_in_valid;
    logic             dec_in_ready = 1'b0;
    logic [7:0]       dec_out_data = 8'h00;
    logic             dec_out_valid = 1'b0;
    logic             dec_out_ready;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_id;
    logic [7:0]       resp_iterations;
    logic [15:0]      resp_cycles;
    logic             resp_timeout;
    logic             busy;

    int tests = 0;
    int fails = 0;
    logic [7:0] cap [$];

    decode_job_arbiter #(
        .GRID_WIDTH_X   (6),
        .GRID_WIDTH_Z   (3),
        .GRID_WIDTH_U   (5),
        .RESP_BYTES     (5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_frame       (req_frame),
        .dec_in_data     (dec_in_data),
        .dec_in_valid    (dec_in_valid),
        .dec_in_ready    (dec_in_ready),
        .dec_out_data    (dec_out_data),
        .dec_out_valid   (dec_out_valid),
        .dec_out_ready   (dec_out_ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_iterations (resp_iterations),
        .resp_cycles     (resp_cycles),
        .resp_timeout    (resp_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Act as the decoder input port: gather n accepted bytes, checking that stalled bytes hold
    task automatic collect_in(input int n, input bit rnd, output int cycles);
        int got = 0;
        logic [7:0] prev_d = 8'h00;
        logic prev_stall = 1'b0;
        cycles = 0;
        cap.delete();
        while (got < n && cycles < 400) begin
            dec_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) check("in_hold", {23'd0, dec_in_valid, dec_in_data}, {23'd0, 1'b1, prev_d});
            if (dec_in_valid && dec_in_ready) begin
                cap.push_back(dec_in_data);
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = dec_in_valid;
                prev_d     = dec_in_data;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        dec_in_ready = 1'b0;
        check("in_count", got, n);
    endtask

    task automatic check_job_bytes(input logic [7:0] base, input bit rnd, output int cycles);
        logic [7:0] b;
        collect_in(FB + 1, rnd, cycles);
        check("header", {24'd0, cap[0]}, {24'd0, HDR});
        for (int i = 1; i <= FB; i++) begin
            b = base + 8'(i - 1);
            check($sformatf("payload%0d", i - 1), {24'd0, cap[i]}, {24'd0, b});
        end
    endtask

    task automatic grant(input logic [1:0] rv, input logic [1:0] exp, input bit hold);
        int cyc = 0;
        req_valid = rv;
        #1;
        while (req_ready == 2'b00 && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("req_ready", {30'd0, req_ready}, {30'd0, exp});
        @(posedge clk);
        #1;
        if (!hold) req_valid = 2'b00;
        check("req_ready_pulse", {30'd0, req_ready}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int cyc = 0;
        dec_out_valid = 1'b1;
        dec_out_data  = d;
        #1;
        while (!dec_out_ready && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("dec_out_ready", {31'd0, dec_out_ready}, 32'd1);
        @(posedge clk);
        #1;
        dec_out_valid = 1'b0;
    endtask

    task automatic take_resp(input logic id, input logic [7:0] it, input logic [15:0] cy, input logic to);
        int cyc = 0;
        while (!resp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_id", {31'd0, resp_id}, {31'd0, id});
        check("resp_iterations", {24'd0, resp_iterations}, {24'd0, it});
        check("resp_cycles", {16'd0, resp_cycles}, {16'd0, cy});
        check("resp_timeout", {31'd0, resp_timeout}, {31'd0, to});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic reset_and_sync();
        int cyc;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        collect_in(1, 1'b0, cyc);
        check("sync_byte", {24'd0, cap[0]}, {24'd0, START});
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        for (int i = 0; i < FB; i++) begin
            req_frame[8*i +: 8]         = 8'(i);
            req_frame[FBITS + 8*i +: 8] = 8'(8'h80 + i);
        end

        // Reset values, then the start message handshakes on the first cycle out of reset
        tick();
        tick();
        check("rst_in_valid", {31'd0, dec_in_valid}, 32'd1);
        check("rst_in_data", {24'd0, dec_in_data}, {24'd0, START});
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_out_ready", {31'd0, dec_out_ready}, 32'd0);
        check("rst_fields", {7'd0, resp_id, resp_iterations, resp_cycles}, 32'd0);
        check("rst_timeout", {31'd0, resp_timeout}, 32'd0);
        reset = 1'b0;
        dec_in_ready = 1'b1;
        tick();
        dec_in_ready = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_in_valid", {31'd0, dec_in_valid}, 32'd0);
        dec_out_valid = 1'b1;
        #1;
        check("idle_backpressure", {31'd0, dec_out_ready}, 32'd0);
        dec_out_valid = 1'b0;
        tick();

        // Single job from requester 0, decoder always ready
        grant(2'b01, 2'b01, 1'b0);
        check_job_bytes(8'h00, 1'b0, cyc);
        check("grant_to_wait_cycles", cyc, 16);
        check("wait_in_valid", {31'd0, dec_in_valid}, 32'd0);
        check("wait_out_ready", {31'd0, dec_out_ready}, 32'd1);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h2C);
        check("no_early_resp", {31'd0, resp_valid}, 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("resp_next_cycle", {31'd0, resp_valid}, 32'd1);
        take_resp(1'b0, 8'h04, 16'h012C, 1'b0);

        // Both requesters held high: grants alternate starting from requester 0
        reset_and_sync();
        for (int j = 0; j < 4; j++) begin
            grant(2'b11, (j % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
            check_job_bytes((j % 2 == 0) ? 8'h00 : 8'h80, 1'b0, cyc);
            send_byte(8'(j + 1));
            send_byte(8'h00);
            send_byte(8'(8'h10 + j));
            send_byte(8'h00);
            send_byte(8'h00);
            take_resp(1'(j % 2), 8'(j + 1), 16'(8'h10 + j), 1'b0);
        end
        req_valid = 2'b00;
        tick();

        // Random decoder back-pressure, trailing response bytes dropped
        grant(2'b01, 2'b01, 1'b0);
        check_job_bytes(8'h00, 1'b1, cyc);
        send_byte(8'h07);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h55);
        send_byte(8'h66);
        take_resp(1'b0, 8'h07, 16'h1234, 1'b0);

        // Silent decoder: watchdog delivers a timed-out response, then resync
        grant(2'b10, 2'b10, 1'b0);
        check_job_bytes(8'h80, 1'b0, cyc);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 16);
        take_resp(1'b1, 8'h00, 16'h0000, 1'b1);
        check("resync_busy", {31'd0, busy}, 32'd1);
        collect_in(1, 1'b0, cyc);
        check("resync_byte", {24'd0, cap[0]}, {24'd0, START});

        // Reset while payload byte 7 is on the wire
        grant(2'b01, 2'b01, 1'b0);
        dec_in_ready = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check("byte7_on_wire", {24'd0, dec_in_data}, 32'h07);
        reset = 1'b1;
        dec_in_ready = 1'b0;
        tick();
        check("abort_in_data", {24'd0, dec_in_data}, {24'd0, START});
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        collect_in(1, 1'b0, cyc);
        check("abort_sync", {24'd0, cap[0]}, {24'd0, START});
        grant(2'b01, 2'b01, 1'b0);
        check_job_bytes(8'h00, 1'b0, cyc);
        send_byte(8'h09);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'h00);
        send_byte(8'h00);
        take_resp(1'b0, 8'h09, 16'hABCD, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
